// File: rtl/rv_sys_monitor.sv
// rv_sys_monitor: system-call and termination monitor for the rv32 core.
// Decodes retiring ecalls by a7 (exit / putc / user event). It buffers console
// characters in a FIFO with a valid/ready drain port. A stall watchdog and a
// global cycle limit catch hung programs. The monitor reports done/pass/cause
// after a drain delay.
//
// Ports:
//   clk, xreset          clock, synchronous active-low reset
//   ir, ir_valid         retiring instruction word and its qualifier
//   a7, a0               x17 / x10 at retire
//   cyc_limit            global cycle limit, 0 disables
//   ch_data, ch_valid    head console character, FIFO not empty
//   ch_ready             consumer accepts ch_data
//   user_evt, user_arg   one-cycle user pulse, a0 of the last user ecall
//   done, pass, cause    run status (cause: 0 run, 1 exit, 2 stall, 3 cycle limit)
//   exit_code            a0 captured at exit
//   ecall_cnt            saturating ecall count
//   overflow             sticky dropped-putc flag
module rv_sys_monitor #(
  parameter int unsigned SYS_EXIT     = 93,
  parameter int unsigned SYS_PUTC     = 64,
  parameter int unsigned SYS_USER     = 100,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned STALL_W      = 16,
  parameter int unsigned CYC_W        = 32,
  parameter int unsigned FINISH_DELAY = 5
) (
  input  logic             clk,
  input  logic             xreset,
  input  logic [31:0]      ir,
  input  logic             ir_valid,
  input  logic [31:0]      a7,
  input  logic [31:0]      a0,
  input  logic [CYC_W-1:0] cyc_limit,
  output logic [7:0]       ch_data,
  output logic             ch_valid,
  input  logic             ch_ready,
  output logic             user_evt,
  output logic [31:0]      user_arg,
  output logic             done,
  output logic             pass,
  output logic [1:0]       cause,
  output logic [31:0]      exit_code,
  output logic [15:0]      ecall_cnt,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = $clog2(FINISH_DELAY + 2);

  localparam logic [AW:0]        FullCnt   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]        CntOne    = (AW+1)'(1);
  localparam logic [AW-1:0]      PtrOne    = AW'(1);
  localparam logic [DW-1:0]      DlyEnd    = DW'(FINISH_DELAY);
  localparam logic [DW-1:0]      DlyOne    = DW'(1);
  localparam logic [STALL_W-1:0] StallOne  = STALL_W'(1);
  // One below all-ones: the counter becomes all-ones on the edge that trips.
  localparam logic [STALL_W-1:0] StallLast = {{(STALL_W-1){1'b1}}, 1'b0};
  localparam logic [CYC_W-1:0]   CycOne    = CYC_W'(1);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic [DW-1:0]      dly_q, dly_d;
  logic [STALL_W-1:0] stall_q;
  logic [CYC_W-1:0]   cyc_q;
  logic               user_evt_q;
  logic [31:0]        user_arg_q, exit_code_q;
  logic [1:0]         cause_q, cause_d;
  logic [15:0]        ecall_cnt_q;
  logic               overflow_q;

  logic in_run, is_ecall, fifo_empty, fifo_full, pop;
  logic do_exit, do_putc, do_user, push_ok, drop, stall_hit, cyc_hit;

  assign in_run     = (state_q == StRun);
  assign is_ecall   = ir_valid && (ir == 32'h0000_0073);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FullCnt);
  assign pop        = !fifo_empty && ch_ready;

  assign do_exit   = in_run && is_ecall && (a7 == SYS_EXIT);
  assign do_putc   = in_run && is_ecall && (a7 == SYS_PUTC);
  assign do_user   = in_run && is_ecall && (a7 == SYS_USER);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = do_putc && (!fifo_full || pop);
  assign drop      = do_putc && fifo_full && !pop;
  assign stall_hit = in_run && !ir_valid && (stall_q == StallLast);
  assign cyc_hit   = in_run && (cyc_limit != '0) && (cyc_q == cyc_limit - CycOne);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cause_d = cause_q;
    unique case (state_q)
      StRun: begin
        dly_d = '0;
        if (do_exit) begin
          cause_d = 2'd1;
          state_d = StDrain;
        end else if (stall_hit) begin
          cause_d = 2'd2;
          state_d = StDrain;
        end else if (cyc_hit) begin
          cause_d = 2'd3;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty && dly_q >= DlyEnd) begin
          state_d = StDone;
        end else begin
          // The delay restarts while characters remain, so the consumer sees
          // the whole tail of the console output before done rises.
          dly_d = fifo_empty ? dly_q + DlyOne : '0;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xreset) begin
      state_q     <= StRun;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      dly_q       <= '0;
      stall_q     <= '0;
      cyc_q       <= '0;
      user_evt_q  <= 1'b0;
      user_arg_q  <= '0;
      exit_code_q <= '0;
      cause_q     <= 2'd0;
      ecall_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      user_evt_q <= do_user;
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop) rptr_q <= rptr_q + PtrOne;
      if (do_user) user_arg_q <= a0;
      if (do_exit) exit_code_q <= a0;
      if (drop) overflow_q <= 1'b1;
      if (in_run && is_ecall && ecall_cnt_q != 16'hFFFF) ecall_cnt_q <= ecall_cnt_q + 16'd1;
      if (in_run) begin
        stall_q <= ir_valid ? '0 : stall_q + StallOne;
        cyc_q   <= cyc_q + CycOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xreset && push_ok) mem[wptr_q] <= a0[7:0];
  end

  assign ch_valid  = !fifo_empty;
  assign ch_data   = fifo_empty ? 8'h00 : mem[rptr_q];
  assign user_evt  = user_evt_q;
  assign user_arg  = user_arg_q;
  assign done      = (state_q == StDone);
  assign pass      = done && (cause_q == 2'd1) && (exit_code_q == '0);
  assign cause     = cause_q;
  assign exit_code = exit_code_q;
  assign ecall_cnt = ecall_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_rv_sys_monitor.sv
// Bench for rv_sys_monitor: directed ecall sequences, a behavioural model built
// on a character queue and plain counters checked every cycle, plus literal
// expectations at the interesting points.
module tb_rv_sys_monitor;
  localparam int unsigned FD   = 16;
  localparam int unsigned SW   = 4;
  localparam int unsigned FDLY = 5;

  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic [31:0] ir = 32'h13;
  logic        ir_valid = 1'b1;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;
  logic [31:0] cyc_limit = '0;
  logic        ch_ready = 1'b0;
  logic [7:0]  ch_data;
  logic        ch_valid, user_evt, done, pass, overflow;
  logic [31:0] user_arg, exit_code;
  logic [1:0]  cause;
  logic [15:0] ecall_cnt;

  int n_checks = 0;
  int n_pass = 0;

  rv_sys_monitor #(
    .FIFO_DEPTH  (FD),
    .STALL_W     (SW),
    .FINISH_DELAY(FDLY)
  ) dut (
    .clk      (clk),
    .xreset   (xreset),
    .ir       (ir),
    .ir_valid (ir_valid),
    .a7       (a7),
    .a0       (a0),
    .cyc_limit(cyc_limit),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .user_evt (user_evt),
    .user_arg (user_arg),
    .done     (done),
    .pass     (pass),
    .cause    (cause),
    .exit_code(exit_code),
    .ecall_cnt(ecall_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Model: 0 running, 1 draining, 2 done.
  byte unsigned q[$];
  int           m_state;
  logic         m_user_evt;
  logic [31:0]  m_user_arg, m_exit;
  logic [1:0]   m_cause;
  int           m_ecalls, m_idle, m_dly;
  longint       m_cyc;
  logic         m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    bit pop, push, ecall;
    int qs;
    logic [1:0] c;
    if (!xreset) begin
      q.delete();
      m_state = 0; m_user_evt = 0; m_user_arg = 0; m_exit = 0; m_cause = 0;
      m_ecalls = 0; m_idle = 0; m_dly = 0; m_cyc = 0; m_ovf = 0;
      return;
    end
    qs = q.size();
    pop = (qs > 0) && ch_ready;
    push = 0;
    c = 0;
    ecall = ir_valid && (ir == 32'h73);
    m_user_evt = 0;
    if (m_state == 0) begin
      if (ecall) begin
        if (m_ecalls < 65535) m_ecalls++;
        if (a7 == 93) c = 1;
        else if (a7 == 64) begin
          if (qs < FD || pop) push = 1;
          else m_ovf = 1;
        end else if (a7 == 100) begin
          m_user_evt = 1;
          m_user_arg = a0;
        end
      end
      if (c == 0 && !ir_valid && m_idle + 1 == (1 << SW) - 1) c = 2;
      if (c == 0 && cyc_limit != 0 && m_cyc == longint'(cyc_limit) - 1) c = 3;
      if (c == 1) m_exit = a0;
      m_idle = ir_valid ? 0 : m_idle + 1;
      m_cyc++;
      if (c != 0) begin
        m_cause = c;
        m_state = 1;
        m_dly = 0;
      end
    end else if (m_state == 1) begin
      if (qs == 0 && m_dly >= FDLY) m_state = 2;
      else m_dly = (qs == 0) ? m_dly + 1 : 0;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(a0[7:0]);
  endtask

  task automatic compare_all();
    check("ch_valid", ch_valid, q.size() > 0);
    check("ch_data", ch_data, (q.size() > 0) ? q[0] : 8'h00);
    check("user_evt", user_evt, m_user_evt);
    check("user_arg", user_arg, m_user_arg);
    check("done", done, m_state == 2);
    check("pass", pass, (m_state == 2) && (m_cause == 1) && (m_exit == 0));
    check("cause", cause, m_cause);
    check("exit_code", exit_code, m_exit);
    check("ecall_cnt", ecall_cnt, m_ecalls);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    ir = 32'h13; ir_valid = 1'b1; a7 = '0; a0 = '0;
    repeat (n) step();
  endtask

  task automatic ecall(input logic [31:0] a7v, input logic [31:0] a0v);
    ir = 32'h73; ir_valid = 1'b1; a7 = a7v; a0 = a0v;
    step();
    ir = 32'h13; a7 = '0; a0 = '0;
  endtask

  task automatic do_reset();
    xreset = 1'b0; ch_ready = 1'b0; ir = 32'h13; ir_valid = 1'b1; a7 = '0; a0 = '0;
    step();
    xreset = 1'b1;
  endtask

  initial begin
    int k;
    // Reset state
    do_reset();
    check("rst_done", done, 0);
    check("rst_cause", cause, 0);
    check("rst_ch_valid", ch_valid, 0);

    // Exit with code 0 at cycle 10: done exactly 6 edges later
    do_reset();
    idle(9);
    ecall(93, 0);
    check("exit_cause", cause, 1);
    repeat (5) step();
    check("exit_done_early", done, 0);
    step();
    check("exit_done", done, 1);
    check("exit_pass", pass, 1);

    // Exit with code 3
    do_reset();
    ecall(93, 3);
    repeat (6) step();
    check("fail_code", exit_code, 3);
    check("fail_pass", pass, 0);
    check("fail_done", done, 1);

    // Other a7 and ebreak do not terminate
    do_reset();
    ecall(92, 0);
    ir = 32'h0010_0073; a7 = 93; step();
    idle(10);
    check("a7_92_done", done, 0);
    check("a7_92_cnt", ecall_cnt, 1);

    // User event
    do_reset();
    ecall(100, 32'hDEAD_BEEF);
    check("user_evt_hi", user_evt, 1);
    check("user_arg", user_arg, 32'hDEAD_BEEF);
    step();
    check("user_evt_lo", user_evt, 0);

    // Console held back, then drained in order
    do_reset();
    ecall(64, 32'h48);
    ecall(64, 32'h69);
    ecall(93, 0);
    idle(20);
    check("con_hold_done", done, 0);
    check("con_head_H", ch_data, 8'h48);
    ch_ready = 1'b1;
    step();
    check("con_head_i", ch_data, 8'h69);
    step();
    check("con_empty", ch_valid, 0);
    k = 0;
    while (!done && k < 20) begin
      step();
      k++;
    end
    check("con_done_delay", k, 6);

    // Overflow: 17 pushes into 16 slots
    do_reset();
    for (int i = 0; i < 17; i++) ecall(64, 32'h61 + i);
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", ecall_cnt, 17);
    ch_ready = 1'b1;
    repeat (16) step();
    check("ovf_drained", ch_valid, 0);

    // Push and pop together when full
    do_reset();
    for (int i = 0; i < 16; i++) ecall(64, 32'h61 + i);
    ch_ready = 1'b1;
    ecall(64, 32'h58);
    check("pp_no_ovf", overflow, 0);
    repeat (15) step();
    check("pp_tail_X", ch_data, 8'h58);

    // Stall watchdog
    do_reset();
    ir_valid = 1'b0;
    repeat (14) step();
    check("stall_pre", cause, 0);
    step();
    check("stall_cause", cause, 2);
    repeat (5) step();
    check("stall_done_early", done, 0);
    step();
    check("stall_done", done, 1);
    check("stall_pass", pass, 0);

    // ir_valid pulse at idle cycle 14 restarts the count
    do_reset();
    ir_valid = 1'b0;
    repeat (13) step();
    ir_valid = 1'b1; step();
    ir_valid = 1'b0;
    repeat (14) step();
    check("stall_restart_pre", cause, 0);
    step();
    check("stall_restart", cause, 2);

    // Cycle limit
    cyc_limit = 50;
    do_reset();
    idle(49);
    check("cyc_pre", cause, 0);
    idle(1);
    check("cyc_cause", cause, 3);

    // Exit beats the cycle limit in the same cycle
    do_reset();
    idle(49);
    ecall(93, 7);
    check("prio_cause", cause, 1);
    check("prio_code", exit_code, 7);
    cyc_limit = 0;

    // Reset while draining clears everything
    do_reset();
    ecall(64, 32'h5A);
    ecall(93, 5);
    idle(3);
    xreset = 1'b0;
    step();
    check("rd_ch_valid", ch_valid, 0);
    check("rd_ch_data", ch_data, 0);
    check("rd_cause", cause, 0);
    check("rd_code", exit_code, 0);
    check("rd_cnt", ecall_cnt, 0);
    xreset = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
